// File: rtl/div8s4u_seq.sv
// Sequential signed-dividend / unsigned-divisor restoring divider.
// Eight iterations on the dividend magnitude; the sign is reapplied in FIX.
module div8s4u_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [4:0] remainder,
    output logic       div_zero,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  dvd_r;
    logic [3:0]  dsr_r;
    logic [7:0]  mag_r;
    logic        sign_r;
    logic [4:0]  div_r;
    logic [2:0]  cnt_r;
    logic [4:0]  prem_r;
    logic [7:0]  q_r;

    logic [4:0]  shifted_s;
    logic        ge_s;
    logic [4:0]  diff_s;
    logic [7:0]  qfix_s;
    logic [4:0]  rfix_s;
    logic        zero_s;

    // Handshake and status flags decode straight from the state register.
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);

    // One restoring step plus the sign fix-up; the partial remainder never
    // exceeds 14, so the shifted value always fits in 5 bits.
    always_comb begin
        shifted_s = {prem_r[3:0], mag_r[7]};
        ge_s      = (shifted_s >= div_r);
        if (ge_s) begin
            diff_s = shifted_s - div_r;
        end else begin
            diff_s = shifted_s;
        end
        if (sign_r) begin
            qfix_s = 8'd0 - q_r;
            rfix_s = 5'd0 - prem_r;
        end else begin
            qfix_s = q_r;
            rfix_s = prem_r;
        end
        zero_s = (div_r == 5'd0);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            dvd_r     <= 8'd0;
            dsr_r     <= 4'd0;
            mag_r     <= 8'd0;
            sign_r    <= 1'b0;
            div_r     <= 5'd0;
            cnt_r     <= 3'd0;
            prem_r    <= 5'd0;
            q_r       <= 8'd0;
            quotient  <= 8'd0;
            remainder <= 5'd0;
            div_zero  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        dvd_r   <= dividend;
                        dsr_r   <= divisor;
                        state_r <= ABS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ABS: begin
                    // -128 maps to 8'h80, read back as unsigned 128.
                    if (dvd_r[7]) begin
                        mag_r <= 8'd0 - dvd_r;
                    end else begin
                        mag_r <= dvd_r;
                    end
                    sign_r  <= dvd_r[7];
                    div_r   <= {1'b0, dsr_r};
                    cnt_r   <= 3'd0;
                    prem_r  <= 5'd0;
                    q_r     <= 8'd0;
                    state_r <= ITER;
                end
                ITER: begin
                    prem_r <= diff_s;
                    q_r    <= {q_r[6:0], ge_s};
                    mag_r  <= {mag_r[6:0], 1'b0};
                    cnt_r  <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= ITER;
                    end
                end
                FIX: begin
                    if (zero_s) begin
                        quotient  <= 8'hFF;
                        remainder <= 5'h00;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= qfix_s;
                        remainder <= rfix_s;
                        div_zero  <= 1'b0;
                    end
                    state_r <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
